regfile_write_arbiter: RTL and testbench

Shares the single write port of the 32 x 64-bit register bank between two requesters: requester 0 is ALU writeback, requester 1 is load writeback. Uses round-robin arbitration with a bounded burst, so one requester may take several consecutive writes before it must yield. Each requester uses a valid/ready handshake. Outputs drive the bank's write_register, write_data and register_write pins directly from flops.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/rr_burst_arbiter.sv | 85 ++++++++
 rtl/regfile_write_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared register-bank geometry and write-arbiter state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_DATA_WIDTH = 64;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_COUNT      = 32;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_own0 = 2'd1;
    localparam logic [1:0] c_st_own1 = 2'd2;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/rr_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_burst_arbiter
// Purpose  : Two-way round-robin arbiter that lets the owner keep the grant
//            for up to MAX_BURST consecutive cycles while the other waits.
// Revision : 1.0 - initial release
// ============================================================================
module rr_burst_arbiter
    import regfile_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic [1:0] grant,
    output logic       last_grant
);

    localparam logic [3:0] c_max_burst = 4'(MAX_BURST);

    logic [1:0] r_state;
    logic [3:0] r_burst_cnt;
    logic       r_last_grant;

    logic [1:0] w_grant;
    logic [1:0] w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_owner;
    logic       w_owner_valid;
    logic       w_other_valid;
    logic       w_pick;

    always_comb begin
        w_grant       = 2'b00;
        w_state_nxt   = c_st_idle;
        w_cnt_nxt     = 4'd0;
        w_pick        = 1'b0;
        w_owner       = (r_state == c_st_own1);
        w_owner_valid = w_owner ? req1_valid : req0_valid;
        w_other_valid = w_owner ? req0_valid : req1_valid;

        if (reset) begin
            w_grant = 2'b00;
        end else if ((r_state != c_st_idle) && w_owner_valid) begin
            if (w_other_valid && (r_burst_cnt >= c_max_burst)) begin
                // Burst exhausted with the other side waiting: hand over.
                w_grant     = w_owner ? 2'b01 : 2'b10;
                w_state_nxt = w_owner ? c_st_own0 : c_st_own1;
                w_cnt_nxt   = 4'd1;
            end else begin
                w_grant     = w_owner ? 2'b10 : 2'b01;
                w_state_nxt = r_state;
                w_cnt_nxt   = (r_burst_cnt >= c_max_burst) ? c_max_burst
                                                           : r_burst_cnt + 4'd1;
            end
        end else if (req0_valid || req1_valid) begin
            // Owner gone (or idle): arbitrate fresh in the same cycle.
            w_pick      = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
            w_grant     = w_pick ? 2'b10 : 2'b01;
            w_state_nxt = w_pick ? c_st_own1 : c_st_own0;
            w_cnt_nxt   = 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_burst_cnt  <= 4'd0;
            r_last_grant <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_cnt_nxt;
            if (w_grant != 2'b00) begin
                r_last_grant <= w_grant[1];
            end
        end
    end

    assign grant      = w_grant;
    assign last_grant = r_last_grant;

endmodule : rr_burst_arbiter
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Shares the register bank write port between ALU and load
//            writeback; optional statistics counters under WRITE_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH       = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH       = REG_ADDR_WIDTH,
    parameter int MAX_BURST        = 4,
    parameter int ZERO_REG_DISCARD = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic [ADDR_WIDTH-1:0] write_register,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  register_write,
    output logic                  last_grant
`ifdef WRITE_ARB_STATS_EN
    ,
    output logic [31:0]           grant_count0,
    output logic [31:0]           grant_count1,
    output logic [31:0]           conflict_count
`endif
);

    logic [1:0]            w_grant;
    logic                  w_accept;
    logic                  w_zero_drop;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;

    logic [ADDR_WIDTH-1:0] r_write_register;
    logic [DATA_WIDTH-1:0] r_write_data;
    logic                  r_register_write;

    rr_burst_arbiter #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .grant      (w_grant),
        .last_grant (last_grant)
    );

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];
    assign w_accept   = |w_grant;
    assign w_sel_addr = w_grant[1] ? req1_addr : req0_addr;
    assign w_sel_data = w_grant[1] ? req1_data : req0_data;

    // Index 0 is hard-wired zero in the bank; the write is consumed silently.
    if (ZERO_REG_DISCARD != 0) begin : g_zero_drop
        assign w_zero_drop = (w_sel_addr == '0);
    end else begin : g_zero_keep
        assign w_zero_drop = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_write_register <= '0;
            r_write_data     <= '0;
            r_register_write <= 1'b0;
        end else begin
            r_register_write <= w_accept && !w_zero_drop;
            if (w_accept) begin
                r_write_register <= w_sel_addr;
                r_write_data     <= w_sel_data;
            end
        end
    end

    assign write_register = r_write_register;
    assign write_data     = r_write_data;
    assign register_write = r_register_write;

`ifdef WRITE_ARB_STATS_EN
    logic [31:0] r_grant_count0;
    logic [31:0] r_grant_count1;
    logic [31:0] r_conflict_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_count0   <= 32'd0;
            r_grant_count1   <= 32'd0;
            r_conflict_count <= 32'd0;
        end else begin
            if (w_grant[0]) r_grant_count0 <= r_grant_count0 + 32'd1;
            if (w_grant[1]) r_grant_count1 <= r_grant_count1 + 32'd1;
            if (req0_valid && req1_valid) r_conflict_count <= r_conflict_count + 32'd1;
        end
    end

    assign grant_count0   = r_grant_count0;
    assign grant_count1   = r_grant_count1;
    assign conflict_count = r_conflict_count;
`endif

endmodule : regfile_write_arbiter
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Directed scoreboard bench for regfile_write_arbiter (two builds:
//            default parameters, and MAX_BURST=2 with ZERO_REG_DISCARD=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [63:0] data;
        logic        lg;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        a_v0 = 1'b0, a_v1 = 1'b0, b_v0 = 1'b0, b_v1 = 1'b0;
    logic [4:0]  a_a0 = '0, a_a1 = '0, b_a0 = '0, b_a1 = '0;
    logic [63:0] a_d0 = '0, a_d1 = '0, b_d0 = '0, b_d1 = '0;
    logic        a_r0, a_r1, a_rw, a_lg, b_r0, b_r1, b_rw, b_lg;
    logic [4:0]  a_wr, b_wr;
    logic [63:0] a_wd, b_wd;
`ifdef WRITE_ARB_STATS_EN
    logic [31:0] a_gc0, a_gc1, a_cc, b_gc0, b_gc1, b_cc;
`endif

    regfile_write_arbiter dut_a (
        .clk            (clk),
        .reset          (reset),
        .req0_valid     (a_v0),
        .req0_addr      (a_a0),
        .req0_data      (a_d0),
        .req0_ready     (a_r0),
        .req1_valid     (a_v1),
        .req1_addr      (a_a1),
        .req1_data      (a_d1),
        .req1_ready     (a_r1),
        .write_register (a_wr),
        .write_data     (a_wd),
        .register_write (a_rw),
        .last_grant     (a_lg)
`ifdef WRITE_ARB_STATS_EN
        ,
        .grant_count0   (a_gc0),
        .grant_count1   (a_gc1),
        .conflict_count (a_cc)
`endif
    );

    regfile_write_arbiter #(
        .MAX_BURST        (2),
        .ZERO_REG_DISCARD (0)
    ) dut_b (
        .clk            (clk),
        .reset          (reset),
        .req0_valid     (b_v0),
        .req0_addr      (b_a0),
        .req0_data      (b_d0),
        .req0_ready     (b_r0),
        .req1_valid     (b_v1),
        .req1_addr      (b_a1),
        .req1_data      (b_d1),
        .req1_ready     (b_r1),
        .write_register (b_wr),
        .write_data     (b_wd),
        .register_write (b_rw),
        .last_grant     (b_lg)
`ifdef WRITE_ARB_STATS_EN
        ,
        .grant_count0   (b_gc0),
        .grant_count1   (b_gc1),
        .conflict_count (b_cc)
`endif
    );

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic lg_a = 1'b1;
    logic lg_b = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic v0, input logic [4:0] ad0, input logic [63:0] dt0,
                         input logic v1, input logic [4:0] ad1, input logic [63:0] dt1);
        if (i == 0) begin
            a_v0 = v0; a_a0 = ad0; a_d0 = dt0; a_v1 = v1; a_a1 = ad1; a_d1 = dt1;
        end else begin
            b_v0 = v0; b_a0 = ad0; b_d0 = dt0; b_v1 = v1; b_a1 = ad1; b_d1 = dt1;
        end
    endtask

    // One clock: check readys against the expected grant, pop and compare the
    // registered write produced by the previous cycle, push this cycle's one.
    task automatic step(input int i, input logic e0, input logic e1, input string tag);
        exp_t        e;
        exp_t        n;
        logic        have;
        logic        o_r0, o_r1, o_rw, o_lg, zd, lgm;
        logic [4:0]  o_wr, ia;
        logic [63:0] o_wd, id;
        @(negedge clk);
        have = 1'b0;
        if (i == 0) begin
            o_r0 = a_r0; o_r1 = a_r1; o_rw = a_rw; o_lg = a_lg; o_wr = a_wr; o_wd = a_wd;
            ia = e1 ? a_a1 : a_a0; id = e1 ? a_d1 : a_d0; zd = 1'b1; lgm = lg_a;
            if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
        end else begin
            o_r0 = b_r0; o_r1 = b_r1; o_rw = b_rw; o_lg = b_lg; o_wr = b_wr; o_wd = b_wd;
            ia = e1 ? b_a1 : b_a0; id = e1 ? b_d1 : b_d0; zd = 1'b0; lgm = lg_b;
            if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
        end
        check($sformatf("%s_ready0", tag), 64'(o_r0), 64'(e0));
        check($sformatf("%s_ready1", tag), 64'(o_r1), 64'(e1));
        if (have) begin
            check($sformatf("%s_regwrite", tag), 64'(o_rw), 64'(e.we));
            check($sformatf("%s_lastgrant", tag), 64'(o_lg), 64'(e.lg));
            if (e.we) begin
                check($sformatf("%s_wreg", tag), 64'(o_wr), 64'(e.addr));
                check($sformatf("%s_wdata", tag), o_wd, e.data);
            end
        end
        n.we = 1'b0; n.addr = '0; n.data = '0;
        if (reset) begin
            lgm = 1'b1;
        end else if (e0 || e1) begin
            n.we   = !(zd && (ia == 5'd0));
            n.addr = ia;
            n.data = id;
            lgm    = e1;
        end
        n.lg = lgm;
        if (i == 0) begin lg_a = lgm; qa.push_back(n); end
        else        begin lg_b = lgm; qb.push_back(n); end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 1'b0, '0, '0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_a_regwrite", 64'(a_rw), 64'd0);
        check("rst_a_wreg", 64'(a_wr), 64'd0);
        check("rst_a_wdata", a_wd, 64'd0);
        check("rst_a_lastgrant", 64'(a_lg), 64'd1);
        check("rst_b_regwrite", 64'(b_rw), 64'd0);
        check("rst_b_lastgrant", 64'(b_lg), 64'd1);
`ifdef WRITE_ARB_STATS_EN
        check("rst_b_gc0", 64'(b_gc0), 64'd0);
        check("rst_b_cc", 64'(b_cc), 64'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        qa.delete();
        qb.delete();
        lg_a = 1'b1;
        lg_b = 1'b1;
    endtask

    initial begin
        int n0;
        int n1;
        int g;

        // Single write and its one-cycle pulse
        do_reset();
        drive(0, 1'b1, 5'd5, 64'hA5, 1'b0, '0, '0);
        step(0, 1'b1, 1'b0, "t1_acc");
        drive(0, 1'b0, '0, '0, 1'b0, '0, '0);
        step(0, 1'b0, 1'b0, "t1_wr");
        step(0, 1'b0, 1'b0, "t1_idle");

        // Both valid, burst of four each way
        do_reset();
        n0 = 0; n1 = 0;
        for (int k = 0; k < 9; k++) begin
            g = (k < 4) ? 0 : ((k < 8) ? 1 : 0);
            drive(0, 1'b1, 5'(1 + n0), 64'h1000 + 64'(n0), 1'b1, 5'(10 + n1), 64'h2000 + 64'(n1));
            step(0, g == 0, g == 1, $sformatf("t2_%0d", k));
            if (g == 0) n0++; else n1++;
        end
        drive(0, 1'b0, '0, '0, 1'b0, '0, '0);
        step(0, 1'b0, 1'b0, "t2_end0");
        step(0, 1'b0, 1'b0, "t2_end1");

        // Lone requester 1 saturates; requester 0 then wins immediately
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(0, 1'b0, '0, '0, 1'b1, 5'(20 + k), 64'h3000 + 64'(k));
            step(0, 1'b0, 1'b1, $sformatf("t3_%0d", k));
        end
        drive(0, 1'b1, 5'd7, 64'h77, 1'b1, 5'd30, 64'h3030);
        step(0, 1'b1, 1'b0, "t3_yield");
        drive(0, 1'b0, '0, '0, 1'b0, '0, '0);
        step(0, 1'b0, 1'b0, "t3_end0");
        step(0, 1'b0, 1'b0, "t3_end1");

        // Index-0 write: discarded on A, written on B
        do_reset();
        drive(0, 1'b1, 5'd0, 64'hFF, 1'b0, '0, '0);
        step(0, 1'b1, 1'b0, "t4a_acc");
        drive(0, 1'b0, '0, '0, 1'b0, '0, '0);
        step(0, 1'b0, 1'b0, "t4a_wr");
        step(0, 1'b0, 1'b0, "t4a_idle");
        drive(1, 1'b1, 5'd0, 64'hFF, 1'b0, '0, '0);
        step(1, 1'b1, 1'b0, "t4b_acc");
        drive(1, 1'b0, '0, '0, 1'b0, '0, '0);
        step(1, 1'b0, 1'b0, "t4b_wr");
        step(1, 1'b0, 1'b0, "t4b_idle");

        // Reset mid-burst with both valid
        do_reset();
        drive(0, 1'b1, 5'd1, 64'h51, 1'b1, 5'd2, 64'h52);
        step(0, 1'b1, 1'b0, "t5_0");
        drive(0, 1'b1, 5'd3, 64'h53, 1'b1, 5'd2, 64'h52);
        step(0, 1'b1, 1'b0, "t5_1");
        reset = 1'b1;
        step(0, 1'b0, 1'b0, "t5_rst");
        reset = 1'b0;
        step(0, 1'b1, 1'b0, "t5_after");
        drive(0, 1'b0, '0, '0, 1'b0, '0, '0);
        step(0, 1'b0, 1'b0, "t5_end0");
        step(0, 1'b0, 1'b0, "t5_end1");

        // MAX_BURST=2 with both valid: 0,0,1,1,0,0
        do_reset();
        n0 = 0; n1 = 0;
        for (int k = 0; k < 6; k++) begin
            g = (k / 2) % 2;
            drive(1, 1'b1, 5'(1 + n0), 64'h6000 + 64'(n0), 1'b1, 5'(8 + n1), 64'h6100 + 64'(n1));
            step(1, g == 0, g == 1, $sformatf("t6_%0d", k));
            if (g == 0) n0++; else n1++;
        end
        drive(1, 1'b0, '0, '0, 1'b0, '0, '0);
        step(1, 1'b0, 1'b0, "t6_end0");
        step(1, 1'b0, 1'b0, "t6_end1");
`ifdef WRITE_ARB_STATS_EN
        check("t6_grant_count0", 64'(b_gc0), 64'd4);
        check("t6_grant_count1", 64'(b_gc1), 64'd2);
        check("t6_conflict_count", 64'(b_cc), 64'd6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_regfile_write_arbiter
`default_nettype wire
